// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard for the riscv32i pipeline: counts in-flight writes
// per architectural register, holds issue on RAW hazards and on WAW depth
// saturation, and retires pending writes as writeback completes.
module regfile_scoreboard #(
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic        issue_wr_rd,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_cycles,
  output logic        wb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0][CNT_W-1:0] r_cnt;
  logic [31:0]            r_stall;
  logic                   r_underflow;

  logic        w_rs1_busy;
  logic        w_rs2_busy;
  logic        w_rd_sat;
  logic        w_ready;
  logic        w_accept_wr;
  logic        w_retire;
  logic [31:0] w_inc;
  logic [31:0] w_dec;
  logic        w_underflow_set;

  // Hazard detection: a source is busy unless its single pending write is
  // retiring right now (bypass); the saturation check never uses the bypass.
  always_comb begin
    w_rs1_busy = (issue_rs1 != 5'd0) && (r_cnt[issue_rs1] != '0) &&
                 !((WB_BYPASS != 0) && wb_valid && (wb_rd == issue_rs1) &&
                   (r_cnt[issue_rs1] == CNT_ONE));
    w_rs2_busy = (issue_rs2 != 5'd0) && (r_cnt[issue_rs2] != '0) &&
                 !((WB_BYPASS != 0) && wb_valid && (wb_rd == issue_rs2) &&
                   (r_cnt[issue_rs2] == CNT_ONE));
    w_rd_sat   = issue_wr_rd && (issue_rd != 5'd0) && (r_cnt[issue_rd] == CNT_MAX);
    w_ready    = !(issue_use_rs1 && w_rs1_busy) &&
                 !(issue_use_rs2 && w_rs2_busy) && !w_rd_sat;
  end

  // Per-register increment/decrement requests and the underflow condition;
  // an accept and retire of the same register cancel, even from zero.
  always_comb begin
    w_accept_wr     = issue_valid && w_ready && issue_wr_rd && (issue_rd != 5'd0);
    w_retire        = wb_valid && (wb_rd != 5'd0);
    w_inc           = w_accept_wr ? (32'd1 << issue_rd) : 32'd0;
    w_dec           = w_retire ? (32'd1 << wb_rd) : 32'd0;
    w_underflow_set = w_retire && !flush && (r_cnt[wb_rd] == '0) &&
                      !(w_accept_wr && (issue_rd == wb_rd));
  end

  // Pending-write counters; flush discards the cycle's accept/retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // Stall counter and sticky underflow flag survive flush, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall     <= 32'd0;
      r_underflow <= 1'b0;
    end else begin
      if (issue_valid && !w_ready && !flush) begin
        r_stall <= r_stall + 32'd1;
      end
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Busy view of the counters; x0 is never tracked.
  always_comb begin
    busy_mask = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busy_mask[i] = (r_cnt[i] != '0);
    end
  end

  assign issue_ready  = w_ready;
  assign stall_cycles = r_stall;
  assign wb_underflow = r_underflow;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (CNT_W=2, WB_BYPASS=1).
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic        issue_wr_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy_mask;
  logic [31:0] stall_cycles;
  logic        wb_underflow;

  int checks   = 0;
  int failures = 0;

  regfile_scoreboard #(.CNT_W(2), .WB_BYPASS(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .issue_wr_rd  (issue_wr_rd),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .busy_mask    (busy_mask),
    .stall_cycles (stall_cycles),
    .wb_underflow (wb_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic wr);
    issue_valid = 1; issue_rs1 = rs1; issue_use_rs1 = u1;
    issue_rs2 = rs2; issue_use_rs2 = u2; issue_rd = rd; issue_wr_rd = wr;
  endtask

  initial begin
    reset = 0;
    idle();
    #1;
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_uflow", {31'd0, wb_underflow}, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    #11 reset = 1;
    step();

    // Basic issue: x7 becomes pending
    issue(5'd5, 1, 5'd6, 1, 5'd7, 1);
    #1 chk("t1_ready", {31'd0, issue_ready}, 32'd1);
    step();
    idle();
    chk("t1_busy", busy_mask, 32'h0000_0080);

    // RAW stall on x7, then bypass on same-cycle writeback
    issue(5'd7, 1, 5'd0, 0, 5'd0, 0);
    #1 chk("t2_stall_ready", {31'd0, issue_ready}, 32'd0);
    step();
    step();
    chk("t2_stall_cnt", stall_cycles, 32'd2);
    wb_valid = 1; wb_rd = 5'd7;
    #1 chk("t2_bypass_ready", {31'd0, issue_ready}, 32'd1);
    step();
    idle();
    chk("t2_busy_clear", busy_mask, 32'h0);
    chk("t2_stall_hold", stall_cycles, 32'd2);

    // WAW saturation on x3
    for (int k = 0; k < 3; k++) begin
      issue(5'd0, 0, 5'd0, 0, 5'd3, 1);
      step();
    end
    chk("t3_busy3", busy_mask, 32'h0000_0008);
    #1 chk("t3_sat_ready", {31'd0, issue_ready}, 32'd0);
    step();
    chk("t3_stall3", stall_cycles, 32'd3);
    wb_valid = 1; wb_rd = 5'd3;
    #1 chk("t3_sat_nobypass", {31'd0, issue_ready}, 32'd0);
    step();
    chk("t3_stall4", stall_cycles, 32'd4);
    wb_valid = 0;
    #1 chk("t3_unsat_ready", {31'd0, issue_ready}, 32'd1);
    step();
    #1 chk("t3_resat_ready", {31'd0, issue_ready}, 32'd0);
    idle();
    wb_valid = 1; wb_rd = 5'd3;
    for (int k = 0; k < 3; k++) step();
    idle();
    chk("t3_drained", busy_mask, 32'h0);
    chk("t3_no_uflow", {31'd0, wb_underflow}, 32'd0);

    // Same-cycle accept and retire on x9
    issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
    step();
    wb_valid = 1; wb_rd = 5'd9;
    #1 chk("t4_ready", {31'd0, issue_ready}, 32'd1);
    step();
    idle();
    chk("t4_busy9", busy_mask, 32'h0000_0200);
    chk("t4_no_uflow", {31'd0, wb_underflow}, 32'd0);
    wb_valid = 1; wb_rd = 5'd9;
    step();
    idle();
    chk("t4_clear", busy_mask, 32'h0);

    // Underflow and x0 handling
    wb_valid = 1; wb_rd = 5'd12;
    step();
    idle();
    chk("t5_uflow_set", {31'd0, wb_underflow}, 32'd1);
    wb_valid = 1; wb_rd = 5'd0;
    step();
    idle();
    chk("t5_uflow_sticky", {31'd0, wb_underflow}, 32'd1);
    chk("t5_wb0_busy", busy_mask, 32'h0);
    issue(5'd0, 0, 5'd0, 0, 5'd0, 1);
    step();
    idle();
    chk("t5_rd0_busy", busy_mask, 32'h0);

    // Flush beats a concurrent accept
    issue(5'd0, 0, 5'd0, 0, 5'd1, 1);
    step();
    issue(5'd0, 0, 5'd0, 0, 5'd2, 1);
    step();
    idle();
    chk("t6_pending", busy_mask, 32'h0000_0006);
    issue(5'd0, 0, 5'd0, 0, 5'd4, 1);
    flush = 1;
    step();
    idle();
    chk("t6_flush_busy", busy_mask, 32'h0);
    chk("t6_flush_stall", stall_cycles, 32'd4);
    chk("t6_flush_uflow", {31'd0, wb_underflow}, 32'd1);

    // Asynchronous reset mid-cycle
    issue(5'd0, 0, 5'd0, 0, 5'd8, 1);
    step();
    idle();
    #2 reset = 0;
    #1;
    chk("t7_rst_stall", stall_cycles, 32'd0);
    chk("t7_rst_uflow", {31'd0, wb_underflow}, 32'd0);
    chk("t7_rst_busy", busy_mask, 32'h0);
    #1 reset = 1;
    step();
    wb_valid = 1; wb_rd = 5'd8;
    step();
    idle();
    chk("t7_post_uflow", {31'd0, wb_underflow}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
